// File: rtl/multicycle_ctrl_fsm.sv
// Multi-cycle control sequencer for the MIPS-subset datapath.
// Moore strobes per state; FETCH/MEMWR handshake strobes also follow mem_ready.
module multicycle_ctrl_fsm #(
  parameter int ST_W = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [5:0]      opcode,
  input  logic [5:0]      funct,
  input  logic            mem_ready,
  output logic            pc_write,
  output logic            branch,
  output logic            branch_ne,
  output logic [1:0]      pc_src,
  output logic            iord,
  output logic            mem_read,
  output logic            mem_write,
  output logic            ir_write,
  output logic            reg_dst,
  output logic            mem_to_reg,
  output logic            reg_write,
  output logic            alu_src_a,
  output logic [1:0]      alu_src_b,
  output logic [2:0]      alu_op,
  output logic            illegal,
  output logic            retire,
  output logic [ST_W-1:0] state
);

  localparam logic [ST_W-1:0] S_FETCH  = ST_W'(0);
  localparam logic [ST_W-1:0] S_DECODE = ST_W'(1);
  localparam logic [ST_W-1:0] S_MEMADR = ST_W'(2);
  localparam logic [ST_W-1:0] S_MEMRD  = ST_W'(3);
  localparam logic [ST_W-1:0] S_MEMWB  = ST_W'(4);
  localparam logic [ST_W-1:0] S_MEMWR  = ST_W'(5);
  localparam logic [ST_W-1:0] S_EXEC   = ST_W'(6);
  localparam logic [ST_W-1:0] S_ALUWB  = ST_W'(7);
  localparam logic [ST_W-1:0] S_BRANCH = ST_W'(8);
  localparam logic [ST_W-1:0] S_IMMEX  = ST_W'(9);
  localparam logic [ST_W-1:0] S_IMMWB  = ST_W'(10);
  localparam logic [ST_W-1:0] S_JUMP   = ST_W'(11);

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_SLTI = 6'b001010;
  localparam logic [5:0] OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;

  logic [ST_W-1:0] state_q, state_d;

  logic       pc_write_c, branch_c, branch_ne_c, iord_c, mem_read_c, mem_write_c;
  logic       ir_write_c, reg_dst_c, mem_to_reg_c, reg_write_c, alu_src_a_c;
  logic       illegal_c, retire_c;
  logic [1:0] pc_src_c, alu_src_b_c;
  logic [2:0] alu_op_c;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_FETCH;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d      = state_q;
    pc_write_c   = 1'b0;
    branch_c     = 1'b0;
    branch_ne_c  = 1'b0;
    pc_src_c     = 2'b00;
    iord_c       = 1'b0;
    mem_read_c   = 1'b0;
    mem_write_c  = 1'b0;
    ir_write_c   = 1'b0;
    reg_dst_c    = 1'b0;
    mem_to_reg_c = 1'b0;
    reg_write_c  = 1'b0;
    alu_src_a_c  = 1'b0;
    alu_src_b_c  = 2'b00;
    alu_op_c     = 3'b000;
    illegal_c    = 1'b0;
    retire_c     = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_read_c  = 1'b1;
        alu_src_b_c = 2'b01;
        ir_write_c  = mem_ready;
        pc_write_c  = mem_ready;
        if (mem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        alu_src_b_c = 2'b11;
        case (opcode)
          OP_LW, OP_SW:                       state_d = S_MEMADR;
          OP_BEQ, OP_BNE:                     state_d = S_BRANCH;
          OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI:  state_d = S_IMMEX;
          OP_J:                               state_d = S_JUMP;
          OP_R: begin
            // funct==0 is a nop: retire straight out of DECODE
            if (funct == 6'd0) begin
              retire_c = 1'b1;
              state_d  = S_FETCH;
            end else begin
              state_d  = S_EXEC;
            end
          end
          default: begin
            illegal_c = 1'b1;
            state_d   = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        alu_src_a_c = 1'b1;
        alu_src_b_c = 2'b10;
        if (opcode == OP_LW)      state_d = S_MEMRD;
        else if (opcode == OP_SW) state_d = S_MEMWR;
        else                      state_d = S_FETCH;
      end
      S_MEMRD: begin
        mem_read_c = 1'b1;
        iord_c     = 1'b1;
        if (mem_ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        mem_to_reg_c = 1'b1;
        reg_write_c  = 1'b1;
        retire_c     = 1'b1;
        state_d      = S_FETCH;
      end
      S_MEMWR: begin
        mem_write_c = 1'b1;
        iord_c      = 1'b1;
        retire_c    = mem_ready;
        if (mem_ready) state_d = S_FETCH;
      end
      S_EXEC: begin
        alu_src_a_c = 1'b1;
        alu_op_c    = 3'b010;
        state_d     = S_ALUWB;
      end
      S_ALUWB: begin
        reg_dst_c   = 1'b1;
        reg_write_c = 1'b1;
        retire_c    = 1'b1;
        state_d     = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a_c = 1'b1;
        alu_op_c    = 3'b001;
        pc_src_c    = 2'b01;
        branch_c    = 1'b1;
        branch_ne_c = (opcode == OP_BNE);
        retire_c    = 1'b1;
        state_d     = S_FETCH;
      end
      S_IMMEX: begin
        alu_src_a_c = 1'b1;
        alu_src_b_c = 2'b10;
        case (opcode)
          OP_ANDI: alu_op_c = 3'b011;
          OP_ORI:  alu_op_c = 3'b100;
          OP_SLTI: alu_op_c = 3'b111;
          default: alu_op_c = 3'b000;
        endcase
        state_d = S_IMMWB;
      end
      S_IMMWB: begin
        reg_write_c = 1'b1;
        retire_c    = 1'b1;
        state_d     = S_FETCH;
      end
      S_JUMP: begin
        pc_src_c   = 2'b10;
        pc_write_c = 1'b1;
        retire_c   = 1'b1;
        state_d    = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
  end

  // rst blanks every strobe combinationally so an in-flight write dies the same cycle
  assign pc_write   = !rst && pc_write_c;
  assign branch     = !rst && branch_c;
  assign branch_ne  = !rst && branch_ne_c;
  assign pc_src     = rst ? 2'b00 : pc_src_c;
  assign iord       = !rst && iord_c;
  assign mem_read   = !rst && mem_read_c;
  assign mem_write  = !rst && mem_write_c;
  assign ir_write   = !rst && ir_write_c;
  assign reg_dst    = !rst && reg_dst_c;
  assign mem_to_reg = !rst && mem_to_reg_c;
  assign reg_write  = !rst && reg_write_c;
  assign alu_src_a  = !rst && alu_src_a_c;
  assign alu_src_b  = rst ? 2'b00 : alu_src_b_c;
  assign alu_op     = rst ? 3'b000 : alu_op_c;
  assign illegal    = !rst && illegal_c;
  assign retire     = !rst && retire_c;
  assign state      = rst ? S_FETCH : state_q;

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Directed-vector bench for multicycle_ctrl_fsm; stimulus pushes expected output
// snapshots into a queue, a negedge monitor pops and compares them.
module tb_multicycle_ctrl_fsm;

  typedef struct packed {
    logic [3:0] st;
    logic       pc_write, branch, branch_ne;
    logic [1:0] pc_src;
    logic       iord, mem_read, mem_write, ir_write;
    logic       reg_dst, mem_to_reg, reg_write, alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic       illegal, retire;
  } exp_t;

  localparam logic [5:0] R = 6'b000000, J = 6'b000010, BEQ = 6'b000100, BNE = 6'b000101;
  localparam logic [5:0] ADDI = 6'b001000, SLTI = 6'b001010, ANDI = 6'b001100, ORI = 6'b001101;
  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, BAD = 6'b111111;
  localparam logic [5:0] F_ADD = 6'b100000;

  logic       clk, rst, mem_ready;
  logic [5:0] opcode, funct;
  logic       pc_write, branch, branch_ne, iord, mem_read, mem_write, ir_write;
  logic       reg_dst, mem_to_reg, reg_write, alu_src_a, illegal, retire;
  logic [1:0] pc_src, alu_src_b;
  logic [2:0] alu_op;
  logic [3:0] state;

  multicycle_ctrl_fsm #(.ST_W(4)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .mem_ready(mem_ready),
    .pc_write(pc_write), .branch(branch), .branch_ne(branch_ne), .pc_src(pc_src),
    .iord(iord), .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .illegal(illegal), .retire(retire), .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  exp_t  exp_q[$];
  string tag_q[$];
  int    checks = 0;
  int    failures = 0;

  exp_t  mon_e, mon_a;
  string mon_t;

  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      mon_e = exp_q.pop_front();
      mon_t = tag_q.pop_front();
      mon_a = '{st:state, pc_write:pc_write, branch:branch, branch_ne:branch_ne, pc_src:pc_src,
                iord:iord, mem_read:mem_read, mem_write:mem_write, ir_write:ir_write,
                reg_dst:reg_dst, mem_to_reg:mem_to_reg, reg_write:reg_write,
                alu_src_a:alu_src_a, alu_src_b:alu_src_b, alu_op:alu_op,
                illegal:illegal, retire:retire};
      checks++;
      if (mon_a !== mon_e) begin
        failures++;
        $display("FAIL %s: got %b required %b (state got %0d required %0d)",
                 mon_t, mon_a, mon_e, mon_a.st, mon_e.st);
      end
    end
  end

  function automatic exp_t z(input logic [3:0] s);
    exp_t e;
    e = '0;
    e.st = s;
    return e;
  endfunction

  task automatic step(input logic r, input logic [5:0] op, input logic [5:0] fn,
                      input logic rdy, input exp_t e, input string tag);
    @(posedge clk);
    #1;
    rst = r; opcode = op; funct = fn; mem_ready = rdy;
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  exp_t E0, F_WAIT, F_RDY, DEC, MA, MRD, MWB, MWR_W, MWR_R, EX, AWB, BR, IMX, IWB, JMP;
  exp_t tmp;

  initial begin
    rst = 1'b1; opcode = R; funct = 6'd0; mem_ready = 1'b0;

    E0 = '0;
    F_WAIT = z(0);  F_WAIT.mem_read = 1; F_WAIT.alu_src_b = 2'b01;
    F_RDY = F_WAIT; F_RDY.ir_write = 1; F_RDY.pc_write = 1;
    DEC = z(1);     DEC.alu_src_b = 2'b11;
    MA  = z(2);     MA.alu_src_a = 1; MA.alu_src_b = 2'b10;
    MRD = z(3);     MRD.mem_read = 1; MRD.iord = 1;
    MWB = z(4);     MWB.mem_to_reg = 1; MWB.reg_write = 1; MWB.retire = 1;
    MWR_W = z(5);   MWR_W.mem_write = 1; MWR_W.iord = 1;
    MWR_R = MWR_W;  MWR_R.retire = 1;
    EX  = z(6);     EX.alu_src_a = 1; EX.alu_op = 3'b010;
    AWB = z(7);     AWB.reg_dst = 1; AWB.reg_write = 1; AWB.retire = 1;
    BR  = z(8);     BR.alu_src_a = 1; BR.alu_op = 3'b001; BR.pc_src = 2'b01;
                    BR.branch = 1; BR.retire = 1;
    IMX = z(9);     IMX.alu_src_a = 1; IMX.alu_src_b = 2'b10;
    IWB = z(10);    IWB.reg_write = 1; IWB.retire = 1;
    JMP = z(11);    JMP.pc_src = 2'b10; JMP.pc_write = 1; JMP.retire = 1;

    // reset state: everything held low while rst is high, even with mem_ready set
    step(1, R, 0, 1, E0, "reset_hold");
    step(0, R, 0, 0, F_WAIT, "reset_release");

    // add
    step(0, R, F_ADD, 1, F_RDY, "add_fetch");
    step(0, R, F_ADD, 0, DEC, "add_decode");
    step(0, R, F_ADD, 1, EX, "add_exec");
    step(0, R, F_ADD, 0, AWB, "add_aluwb");

    // lw with two wait cycles in MEMRD
    step(0, LW, 0, 1, F_RDY, "lw_fetch");
    step(0, LW, 0, 0, DEC, "lw_decode");
    step(0, LW, 0, 0, MA, "lw_memadr");
    step(0, LW, 0, 0, MRD, "lw_memrd_w1");
    step(0, LW, 0, 0, MRD, "lw_memrd_w2");
    step(0, LW, 0, 1, MRD, "lw_memrd_rdy");
    step(0, LW, 0, 0, MWB, "lw_memwb");

    // bne then beq
    tmp = BR; tmp.branch_ne = 1;
    step(0, BNE, 0, 1, F_RDY, "bne_fetch");
    step(0, BNE, 0, 1, DEC, "bne_decode");
    step(0, BNE, 0, 1, tmp, "bne_branch");
    step(0, BEQ, 0, 1, F_RDY, "beq_fetch");
    step(0, BEQ, 0, 1, DEC, "beq_decode");
    step(0, BEQ, 0, 1, BR, "beq_branch");

    // FETCH stall of 3 cycles, then a jump
    step(0, J, 0, 0, F_WAIT, "fetch_wait1");
    step(0, J, 0, 0, F_WAIT, "fetch_wait2");
    step(0, J, 0, 0, F_WAIT, "fetch_wait3");
    step(0, J, 0, 1, F_RDY, "fetch_rdy");
    step(0, J, 0, 0, DEC, "j_decode");
    step(0, J, 0, 0, JMP, "j_jump");

    // illegal opcode
    tmp = DEC; tmp.illegal = 1;
    step(0, BAD, 0, 1, F_RDY, "ill_fetch");
    step(0, BAD, 0, 1, tmp, "ill_decode");
    step(0, BAD, 0, 0, F_WAIT, "ill_back_fetch");

    // nop retires from DECODE
    tmp = DEC; tmp.retire = 1;
    step(0, R, 0, 1, F_RDY, "nop_fetch");
    step(0, R, 0, 1, tmp, "nop_decode");

    // immediates
    tmp = IMX; tmp.alu_op = 3'b111;
    step(0, SLTI, 0, 1, F_RDY, "slti_fetch");
    step(0, SLTI, 0, 1, DEC, "slti_decode");
    step(0, SLTI, 0, 1, tmp, "slti_immex");
    step(0, SLTI, 0, 1, IWB, "slti_immwb");
    tmp = IMX; tmp.alu_op = 3'b100;
    step(0, ORI, 0, 1, F_RDY, "ori_fetch");
    step(0, ORI, 0, 1, DEC, "ori_decode");
    step(0, ORI, 0, 1, tmp, "ori_immex");
    step(0, ORI, 0, 1, IWB, "ori_immwb");
    tmp = IMX; tmp.alu_op = 3'b011;
    step(0, ANDI, 0, 1, F_RDY, "andi_fetch");
    step(0, ANDI, 0, 1, DEC, "andi_decode");
    step(0, ANDI, 0, 1, tmp, "andi_immex");
    step(0, ANDI, 0, 1, IWB, "andi_immwb");
    step(0, ADDI, 0, 1, F_RDY, "addi_fetch");
    step(0, ADDI, 0, 1, DEC, "addi_decode");
    step(0, ADDI, 0, 1, IMX, "addi_immex");
    step(0, ADDI, 0, 1, IWB, "addi_immwb");

    // sw with one wait, then complete
    step(0, SW, 0, 1, F_RDY, "sw_fetch");
    step(0, SW, 0, 1, DEC, "sw_decode");
    step(0, SW, 0, 1, MA, "sw_memadr");
    step(0, SW, 0, 0, MWR_W, "sw_memwr_wait");
    step(0, SW, 0, 1, MWR_R, "sw_memwr_rdy");

    // reset mid-store: write must vanish the same cycle
    step(0, SW, 0, 1, F_RDY, "sw2_fetch");
    step(0, SW, 0, 1, DEC, "sw2_decode");
    step(0, SW, 0, 1, MA, "sw2_memadr");
    step(0, SW, 0, 0, MWR_W, "sw2_memwr_hold");
    step(1, SW, 0, 1, E0, "rst_mid_store");
    step(0, R, F_ADD, 0, F_WAIT, "after_rst_fetch");

    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
    if (exp_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain: got %0d pending snapshots required 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
